quadrilatero_operand_dispatcher: RTL and testbench

- Generalised successor of the Quadrilatero instruction dispatcher. Sits between the decoder and the RF sequencer / execution-unit issue queues.
- Accepts one decoded matrix instruction at a time and dispatches it to the selected execution unit.
- Serially pushes one read/write reservation per matrix operand into the per-register rw queues. Honours queue-full backpressure and same-register conflicts.
- Adds over the previous generation: arbitrary read-operand count, a one-reservation-per-register-per-cycle arbiter, synchronous flush, and a busy indication.

---
 rtl/quadrilatero_operand_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_quadrilatero_operand_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_operand_dispatcher.sv
// Quadrilatero operand dispatcher.
// Accepts one decoded matrix instruction at a time, pulses the target
// execution unit, and serially pushes one read/write reservation per
// matrix operand into the per-register rw queues. At most one reservation
// per register is pushed per cycle, in ascending operand order, so the
// writeback reservation always lands behind any reads of the same register.
module quadrilatero_operand_dispatcher #(
  parameter int N_REGS         = 8,
  parameter int NUM_EXEC_UNITS = 3,
  parameter int N_RD_OPS       = 3,
  parameter int ID_WIDTH       = 4,
  localparam int RW  = $clog2(N_REGS),
  localparam int NW  = $clog2(N_RD_OPS + 1),
  localparam int EUW = (NUM_EXEC_UNITS > 1) ? $clog2(NUM_EXEC_UNITS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [ID_WIDTH-1:0]      instr_id_i,
  input  logic [EUW-1:0]           exec_unit_i,
  input  logic [NW-1:0]            n_rd_i,
  input  logic [N_RD_OPS*RW-1:0]   rd_regs_i,
  input  logic                     wb_i,
  input  logic [RW-1:0]            wb_reg_i,
  input  logic [NUM_EXEC_UNITS-1:0] issue_queue_full_i,
  output logic [NUM_EXEC_UNITS-1:0] dispatch_o,
  output logic [ID_WIDTH-1:0]      instr_id_o,
  input  logic [N_REGS-1:0]        rw_queue_full_i,
  output logic [N_REGS-1:0]        rw_push_o,
  output logic [N_REGS-1:0]        rw_rvalid_o,
  output logic [N_REGS-1:0]        rw_wready_o,
  output logic [ID_WIDTH-1:0]      rw_id_o,
  output logic                     busy_o
);

  // Operand slots: reads occupy 0..N_RD_OPS-1, the writeback is the last slot.
  localparam int NOPS = N_RD_OPS + 1;
  localparam logic [EUW:0] NEU = (EUW + 1)'(NUM_EXEC_UNITS);
  localparam logic [NW-1:0] MAX_RD = NW'(N_RD_OPS);

  typedef enum logic {
    IDLE,
    PUSH
  } state_t;

  state_t                    state_q;
  logic [NOPS-1:0]           pend_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [N_RD_OPS*RW-1:0]    rd_regs_q;
  logic [RW-1:0]             wb_reg_q;
  logic [NUM_EXEC_UNITS-1:0] dispatch_q;

  logic [RW-1:0]             op_reg [NOPS];
  logic [NOPS-1:0]           grant;
  logic [N_REGS-1:0]         taken;
  logic [N_REGS-1:0]         rvalid;
  logic [N_REGS-1:0]         wready;
  logic                      done_now;
  logic                      eu_ok;
  logic                      iq_full_sel;
  logic                      accept;
  logic [NW-1:0]             n_eff;
  logic [NOPS-1:0]           new_pend;
  logic [NUM_EXEC_UNITS-1:0] disp_next;

  // Map each operand slot of the held instruction to its register index.
  always_comb begin
    for (int k = 0; k < NOPS; k++) begin
      op_reg[k] = '0;
    end
    for (int k = 0; k < N_RD_OPS; k++) begin
      op_reg[k] = rd_regs_q[k*RW +: RW];
    end
    op_reg[N_RD_OPS] = wb_reg_q;
  end

  // Grant pending operands in index order, one per register per cycle.
  always_comb begin
    grant  = '0;
    taken  = '0;
    rvalid = '0;
    wready = '0;
    for (int k = 0; k < NOPS; k++) begin
      if (state_q == PUSH && !flush_i && pend_q[k] &&
          !rw_queue_full_i[op_reg[k]] && !taken[op_reg[k]]) begin
        grant[k]          = 1'b1;
        taken[op_reg[k]]  = 1'b1;
        if (k == N_RD_OPS) begin
          wready[op_reg[k]] = 1'b1;
        end else begin
          rvalid[op_reg[k]] = 1'b1;
        end
      end
    end
  end

  // Decode the incoming instruction: target EU checks and new pending mask.
  always_comb begin
    eu_ok       = ({1'b0, exec_unit_i} < NEU);
    iq_full_sel = 1'b0;
    disp_next   = '0;
    for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
      if (exec_unit_i == EUW'(e)) begin
        iq_full_sel  = issue_queue_full_i[e];
        disp_next[e] = 1'b1;
      end
    end
    n_eff    = (n_rd_i > MAX_RD) ? MAX_RD : n_rd_i;
    new_pend = '0;
    for (int k = 0; k < N_RD_OPS; k++) begin
      new_pend[k] = (NW'(k) < n_eff);
    end
    new_pend[N_RD_OPS] = wb_i;
  end

  assign done_now      = (state_q == PUSH) && ((pend_q & ~grant) == '0);
  assign instr_ready_o = !flush_i && eu_ok && !iq_full_sel &&
                         ((state_q == IDLE) || done_now);
  assign accept        = instr_valid_i && instr_ready_o;

  assign rw_rvalid_o = rvalid;
  assign rw_wready_o = wready;
  assign rw_push_o   = rvalid | wready;
  assign dispatch_o  = dispatch_q & {NUM_EXEC_UNITS{~flush_i}};
  assign instr_id_o  = id_q;
  assign rw_id_o     = id_q;
  assign busy_o      = (state_q == PUSH);

  // Dispatcher FSM: latch on accept, retire granted operands, abort on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      id_q       <= '0;
      rd_regs_q  <= '0;
      wb_reg_q   <= '0;
      dispatch_q <= '0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      dispatch_q <= '0;
    end else if (accept) begin
      state_q    <= PUSH;
      pend_q     <= new_pend;
      id_q       <= instr_id_i;
      rd_regs_q  <= rd_regs_i;
      wb_reg_q   <= wb_reg_i;
      dispatch_q <= disp_next;
    end else begin
      dispatch_q <= '0;
      if (done_now) begin
        state_q <= IDLE;
        pend_q  <= '0;
      end else begin
        pend_q <= pend_q & ~grant;
      end
    end
  end

endmodule

// File: tb/tb_quadrilatero_operand_dispatcher.sv
// Directed bench for the Quadrilatero operand dispatcher.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_quadrilatero_operand_dispatcher;

  logic       clk_i;
  logic       rst_ni;
  logic       flush_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [3:0] instr_id_i;
  logic [1:0] exec_unit_i;
  logic [1:0] n_rd_i;
  logic [8:0] rd_regs_i;
  logic       wb_i;
  logic [2:0] wb_reg_i;
  logic [2:0] issue_queue_full_i;
  logic [2:0] dispatch_o;
  logic [3:0] instr_id_o;
  logic [7:0] rw_queue_full_i;
  logic [7:0] rw_push_o;
  logic [7:0] rw_rvalid_o;
  logic [7:0] rw_wready_o;
  logic [3:0] rw_id_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  quadrilatero_operand_dispatcher dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .instr_valid_i      (instr_valid_i),
    .instr_ready_o      (instr_ready_o),
    .instr_id_i         (instr_id_i),
    .exec_unit_i        (exec_unit_i),
    .n_rd_i             (n_rd_i),
    .rd_regs_i          (rd_regs_i),
    .wb_i               (wb_i),
    .wb_reg_i           (wb_reg_i),
    .issue_queue_full_i (issue_queue_full_i),
    .dispatch_o         (dispatch_o),
    .instr_id_o         (instr_id_o),
    .rw_queue_full_i    (rw_queue_full_i),
    .rw_push_o          (rw_push_o),
    .rw_rvalid_o        (rw_rvalid_o),
    .rw_wready_o        (rw_wready_o),
    .rw_id_o            (rw_id_o),
    .busy_o             (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one instruction on the decoder interface.
  task automatic applyStimulus(input logic [3:0] id, input logic [1:0] eu, input logic [1:0] nrd,
                               input logic [8:0] regs, input logic wb, input logic [2:0] wbr);
    instr_valid_i = 1'b1;
    instr_id_i    = id;
    exec_unit_i   = eu;
    n_rd_i        = nrd;
    rd_regs_i     = regs;
    wb_i          = wb;
    wb_reg_i      = wbr;
  endtask

  initial begin
    rst_ni             = 1'b0;
    flush_i            = 1'b0;
    instr_valid_i      = 1'b0;
    instr_id_i         = '0;
    exec_unit_i        = '0;
    n_rd_i             = '0;
    rd_regs_i          = '0;
    wb_i               = 1'b0;
    wb_reg_i           = '0;
    issue_queue_full_i = '0;
    rw_queue_full_i    = '0;

    // Reset state
    #3;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_dispatch", dispatch_o, 0);
    checkOutput("rst_push", rw_push_o, 0);
    checkOutput("rst_id", instr_id_o, 0);
    checkOutput("rst_ready", instr_ready_o, 1);
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: id 5, eu 1, reads {2,3}, write 4
    applyStimulus(4'd5, 2'd1, 2'd2, {3'd0, 3'd3, 3'd2}, 1'b1, 3'd4);
    #2;
    checkOutput("t1_ready", instr_ready_o, 1);
    checkOutput("t1_idle", busy_o, 0);
    tick();
    instr_valid_i = 1'b0;
    #2;
    checkOutput("t1_dispatch", dispatch_o, 3'b010);
    checkOutput("t1_push", rw_push_o, 8'h1C);
    checkOutput("t1_rvalid", rw_rvalid_o, 8'h0C);
    checkOutput("t1_wready", rw_wready_o, 8'h10);
    checkOutput("t1_rw_id", rw_id_o, 5);
    checkOutput("t1_instr_id", instr_id_o, 5);
    checkOutput("t1_busy", busy_o, 1);
    checkOutput("t1_ready_done", instr_ready_o, 1);
    tick();
    #2;
    checkOutput("t1_back_idle", busy_o, 0);
    checkOutput("t1_no_push", rw_push_o, 0);
    checkOutput("t1_pulse_once", dispatch_o, 0);

    // 2: reads {1,1,1}, write 1 -> serialised on reg 1
    applyStimulus(4'd6, 2'd0, 2'd3, {3'd1, 3'd1, 3'd1}, 1'b1, 3'd1);
    tick();
    instr_valid_i = 1'b0;
    #2;
    checkOutput("t2_c1_dispatch", dispatch_o, 3'b001);
    checkOutput("t2_c1_rvalid", rw_rvalid_o, 8'h02);
    checkOutput("t2_c1_wready", rw_wready_o, 8'h00);
    checkOutput("t2_c1_ready", instr_ready_o, 0);
    tick();
    #2;
    checkOutput("t2_c2_rvalid", rw_rvalid_o, 8'h02);
    checkOutput("t2_c2_ready", instr_ready_o, 0);
    checkOutput("t2_c2_dispatch", dispatch_o, 0);
    tick();
    #2;
    checkOutput("t2_c3_rvalid", rw_rvalid_o, 8'h02);
    checkOutput("t2_c3_wready", rw_wready_o, 8'h00);
    checkOutput("t2_c3_ready", instr_ready_o, 0);
    tick();
    #2;
    checkOutput("t2_c4_rvalid", rw_rvalid_o, 8'h00);
    checkOutput("t2_c4_wready", rw_wready_o, 8'h02);
    checkOutput("t2_c4_push", rw_push_o, 8'h02);
    checkOutput("t2_c4_ready", instr_ready_o, 1);
    tick();
    #2;
    checkOutput("t2_idle", busy_o, 0);

    // 3: reads {0,6}, reg 6 queue full for three PUSH cycles
    applyStimulus(4'd7, 2'd2, 2'd2, {3'd0, 3'd6, 3'd0}, 1'b0, 3'd0);
    rw_queue_full_i = 8'h40;
    tick();
    instr_valid_i = 1'b0;
    #2;
    checkOutput("t3_c1_dispatch", dispatch_o, 3'b100);
    checkOutput("t3_c1_push", rw_push_o, 8'h01);
    checkOutput("t3_c1_busy", busy_o, 1);
    tick();
    #2;
    checkOutput("t3_c2_push", rw_push_o, 8'h00);
    checkOutput("t3_c2_busy", busy_o, 1);
    tick();
    #2;
    checkOutput("t3_c3_push", rw_push_o, 8'h00);
    checkOutput("t3_c3_busy", busy_o, 1);
    tick();
    rw_queue_full_i = 8'h00;
    #2;
    checkOutput("t3_c4_rvalid", rw_rvalid_o, 8'h40);
    checkOutput("t3_c4_busy", busy_o, 1);
    checkOutput("t3_c4_ready", instr_ready_o, 1);
    tick();
    #2;
    checkOutput("t3_idle", busy_o, 0);

    // 4: back-to-back single-read instructions
    applyStimulus(4'd8, 2'd0, 2'd1, {3'd0, 3'd0, 3'd5}, 1'b0, 3'd0);
    tick();
    applyStimulus(4'd9, 2'd1, 2'd1, {3'd0, 3'd0, 3'd2}, 1'b0, 3'd0);
    #2;
    checkOutput("t4_a_dispatch", dispatch_o, 3'b001);
    checkOutput("t4_a_push", rw_push_o, 8'h20);
    checkOutput("t4_a_ready", instr_ready_o, 1);
    checkOutput("t4_a_id", instr_id_o, 8);
    tick();
    instr_valid_i = 1'b0;
    #2;
    checkOutput("t4_b_dispatch", dispatch_o, 3'b010);
    checkOutput("t4_b_push", rw_push_o, 8'h04);
    checkOutput("t4_b_id", rw_id_o, 9);
    checkOutput("t4_b_busy", busy_o, 1);
    tick();
    #2;
    checkOutput("t4_idle", busy_o, 0);

    // 5: issue queue full and out-of-range EU block acceptance
    applyStimulus(4'd3, 2'd1, 2'd1, {3'd0, 3'd0, 3'd3}, 1'b0, 3'd0);
    issue_queue_full_i = 3'b010;
    #2;
    checkOutput("t5_iqfull_ready", instr_ready_o, 0);
    tick();
    #2;
    checkOutput("t5_iqfull_busy", busy_o, 0);
    checkOutput("t5_iqfull_push", rw_push_o, 0);
    issue_queue_full_i = 3'b000;
    exec_unit_i        = 2'd3;
    #1;
    checkOutput("t5_eu3_ready", instr_ready_o, 0);
    tick();
    #2;
    checkOutput("t5_eu3_busy", busy_o, 0);
    checkOutput("t5_eu3_dispatch", dispatch_o, 0);
    instr_valid_i = 1'b0;
    exec_unit_i   = 2'd2;
    #1;
    checkOutput("t5_eu2_ready", instr_ready_o, 1);

    // 6: zero-operand instruction occupies PUSH for one cycle
    tick();
    applyStimulus(4'd4, 2'd2, 2'd0, 9'd0, 1'b0, 3'd0);
    tick();
    instr_valid_i = 1'b0;
    #2;
    checkOutput("t6_busy", busy_o, 1);
    checkOutput("t6_push", rw_push_o, 0);
    checkOutput("t6_dispatch", dispatch_o, 3'b100);
    checkOutput("t6_ready", instr_ready_o, 1);
    tick();
    #2;
    checkOutput("t6_idle", busy_o, 0);

    // 7: flush in the cycle after accept, reg 4 stalls
    applyStimulus(4'd10, 2'd0, 2'd2, {3'd0, 3'd4, 3'd3}, 1'b0, 3'd0);
    rw_queue_full_i = 8'h10;
    tick();
    instr_valid_i = 1'b0;
    flush_i       = 1'b1;
    #2;
    checkOutput("t7_flush_dispatch", dispatch_o, 0);
    checkOutput("t7_flush_push", rw_push_o, 0);
    checkOutput("t7_flush_ready", instr_ready_o, 0);
    checkOutput("t7_flush_busy", busy_o, 1);
    tick();
    flush_i         = 1'b0;
    rw_queue_full_i = 8'h00;
    #2;
    checkOutput("t7_after_busy", busy_o, 0);
    checkOutput("t7_after_push", rw_push_o, 0);
    checkOutput("t7_after_dispatch", dispatch_o, 0);

    // 8: reset mid-PUSH discards the instruction
    tick();
    applyStimulus(4'd11, 2'd1, 2'd1, {3'd0, 3'd0, 3'd7}, 1'b0, 3'd0);
    rw_queue_full_i = 8'h80;
    tick();
    instr_valid_i = 1'b0;
    #2;
    checkOutput("t8_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    checkOutput("t8_rst_busy", busy_o, 0);
    checkOutput("t8_rst_push", rw_push_o, 0);
    checkOutput("t8_rst_dispatch", dispatch_o, 0);
    checkOutput("t8_rst_id", instr_id_o, 0);
    tick();
    rst_ni          = 1'b1;
    rw_queue_full_i = 8'h00;
    #2;
    checkOutput("t8_rel_push", rw_push_o, 0);
    checkOutput("t8_rel_busy", busy_o, 0);
    tick();
    #2;
    checkOutput("t8_rel2_push", rw_push_o, 0);
    checkOutput("t8_rel2_dispatch", dispatch_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
